// File: rtl/sid_waveform_bank.sv
// sid_waveform_bank: time-multiplexed SID oscillator and waveform bank.
// Each tick runs one sweep: CALC (adders, pulse compare), COMMIT (osc/noise
// update with hard sync and test handling), then EMIT (one voice per cycle).
module sid_waveform_bank #(
   parameter int VOICES    = 3,
   parameter int OSC_W     = 24,
   parameter int NOISE_TTL = 'h8000,
   parameter int OSC_INIT  = 1
) (
   input  logic                      clk,
   input  logic                      res,
   input  logic                      tick,
   input  logic [VOICES*16-1:0]      freq,
   input  logic [VOICES*12-1:0]      pw,
   input  logic [VOICES*8-1:0]       ctrl,
   output logic                      busy,
   output logic                      overrun,
   output logic                      out_valid,
   output logic [$clog2(VOICES)-1:0] out_voice,
   output logic [3:0]                out_sel,
   output logic [11:0]               out_saw_tri,
   output logic                      out_pulse,
   output logic [7:0]                out_noise
);

   localparam int VW  = $clog2(VOICES);
   localparam int MSB = OSC_W - 1;
   localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

   // ctrl bit positions
   localparam int C_NOISE = 7;
   localparam int C_PULSE = 6;
   localparam int C_SAW   = 5;
   localparam int C_TRI   = 4;
   localparam int C_TEST  = 3;
   localparam int C_RING  = 2;
   localparam int C_SYNC  = 1;

   // LFSR bits routed to out_noise: 20,18,14,11,9,5,2,0
   localparam logic [22:0] TAP_MASK = 23'h144A25;

   function automatic logic [OSC_W-1:0] init_pattern();
      logic [OSC_W-1:0] p;
      p = '0;
      if (OSC_INIT != 0) begin
         for (int unsigned i = 0; i < OSC_W; i += 2) p[i] = 1'b1;
      end
      return p;
   endfunction

   localparam logic [OSC_W-1:0] OSC_RST = init_pattern();

   function automatic logic [7:0] taps(input logic [22:0] n);
      return {n[20], n[18], n[14], n[11], n[9], n[5], n[2], n[0]};
   endfunction

   typedef enum logic [1:0] {IDLE, CALC, COMMIT, EMIT} state_t;

   state_t          state, state_nx;
   logic [VW-1:0]   idx, idx_nx;

   // per-voice state
   logic [OSC_W-1:0] osc        [VOICES];
   logic [OSC_W-1:0] nxt        [VOICES];
   logic             rise       [VOICES];
   logic [22:0]      noise      [VOICES];
   logic             pulse      [VOICES];
   logic             osc19_prev [VOICES];
   logic [23:0]      test_age   [VOICES];

   // unpacked per-voice inputs
   logic [15:0] f_arr [VOICES];
   logic [11:0] p_arr [VOICES];
   logic [7:0]  c_arr [VOICES];
   logic        gate_unused;

   // current-voice datapath
   logic [VW-1:0]    src, src2;
   logic [7:0]       cv;
   logic             test_v, rise_now, pulse_now, req_v, req_s, zero_v, x;
   logic [OSC_W-1:0] sum, new_osc;
   logic [22:0]      noise_nx;
   logic [23:0]      age_nx;
   logic [11:0]      top, saw_tri;

   // Split the packed per-voice buses; gate belongs to the envelope, not here
   always_comb begin
      gate_unused = 1'b0;
      for (int unsigned v = 0; v < VOICES; v++) begin
         f_arr[v]    = freq[16*v +: 16];
         p_arr[v]    = pw[12*v +: 12];
         c_arr[v]    = ctrl[8*v +: 8];
         gate_unused = gate_unused ^ c_arr[v][0];
      end
   end

   // Datapath for the voice selected by idx (shared by CALC, COMMIT and EMIT)
   always_comb begin
      src       = (idx == '0) ? LAST : idx - 1'b1;
      src2      = (src == '0) ? LAST : src - 1'b1;
      cv        = c_arr[idx];
      test_v    = cv[C_TEST];
      sum       = osc[idx] + OSC_W'(f_arr[idx]);
      rise_now  = ~osc[idx][MSB] & sum[MSB];
      pulse_now = (osc[idx][MSB -: 12] >= p_arr[idx]) | test_v;
      // a voice is only synced when its source is not itself being synced,
      // so a full ring of simultaneous requests cancels out
      req_v     = cv[C_SYNC] & rise[src];
      req_s     = c_arr[src][C_SYNC] & rise[src2];
      zero_v    = test_v | (req_v & ~req_s & ~c_arr[src][C_TEST]);
      new_osc   = zero_v ? '0 : nxt[idx];

      noise_nx  = noise[idx];
      age_nx    = test_age[idx];
      if (test_v) begin
         if (test_age[idx] == 24'(NOISE_TTL)) noise_nx = '1;
         if (test_age[idx] != '1) age_nx = test_age[idx] + 24'd1;
      end else if (test_age[idx] != '0) begin
         // nonzero age with test low marks the falling edge of test
         noise_nx = {noise[idx][21:0], 1'b1};
         age_nx   = '0;
      end else if (~osc19_prev[idx] & new_osc[OSC_W-5]) begin
         noise_nx = {noise[idx][21:0], noise[idx][22] ^ noise[idx][17]};
      end
      if (cv[C_NOISE] & (cv[C_PULSE] | cv[C_SAW] | cv[C_TRI])) begin
         noise_nx = noise_nx & ~TAP_MASK;
      end

      top     = osc[idx][MSB -: 12];
      x       = ~cv[C_SAW] & (osc[idx][MSB] ^ (cv[C_RING] & ~osc[src][MSB]));
      saw_tri = {top[11], top[10:0] ^ {11{x}}};
   end

   // Next-state logic: each active state walks idx over all voices
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      busy     = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_nx = CALC;
               idx_nx   = '0;
            end
         end
         CALC: begin
            if (idx == LAST) begin
               state_nx = COMMIT;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
         COMMIT: begin
            if (idx == LAST) begin
               state_nx = EMIT;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
         EMIT: begin
            if (idx == LAST) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
      endcase
   end

   // FSM state, voice index and sticky overrun flag
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state   <= IDLE;
         idx     <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (tick && busy) overrun <= 1'b1;
      end
   end

   // Per-voice state: CALC stages adder/pulse results, COMMIT applies them
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         for (int unsigned v = 0; v < VOICES; v++) begin
            osc[v]        <= OSC_RST;
            nxt[v]        <= '0;
            rise[v]       <= 1'b0;
            noise[v]      <= '1;
            pulse[v]      <= 1'b0;
            osc19_prev[v] <= 1'b0;
            test_age[v]   <= '0;
         end
      end else begin
         unique case (state)
            CALC: begin
               nxt[idx]   <= sum;
               rise[idx]  <= rise_now;
               pulse[idx] <= pulse_now;
            end
            COMMIT: begin
               osc[idx]        <= new_osc;
               noise[idx]      <= noise_nx;
               test_age[idx]   <= age_nx;
               osc19_prev[idx] <= new_osc[OSC_W-5];
            end
            default: ;
         endcase
      end
   end

   // Registered emit port; fields hold between emits
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         out_valid   <= 1'b0;
         out_voice   <= '0;
         out_sel     <= '0;
         out_saw_tri <= '0;
         out_pulse   <= 1'b0;
         out_noise   <= '0;
      end else begin
         out_valid <= (state == EMIT);
         if (state == EMIT) begin
            out_voice   <= idx;
            out_sel     <= cv[7:4];
            out_saw_tri <= saw_tri;
            out_pulse   <= pulse[idx];
            out_noise   <= taps(noise[idx]);
         end
      end
   end

endmodule

// File: tb/tb_sid_waveform_bank.sv
// Bench for sid_waveform_bank: sweep-level reference model plus literal pins.
module tb_sid_waveform_bank;

   localparam int V   = 3;
   localparam int OW  = 24;
   localparam int TTL = 6;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        tick = 1'b0;
   logic [15:0] f [3];
   logic [11:0] p [3];
   logic [7:0]  c [3];
   logic [47:0] freq;
   logic [35:0] pw;
   logic [23:0] ctrl;
   logic        busy, overrun, out_valid, out_pulse;
   logic [1:0]  out_voice;
   logic [3:0]  out_sel;
   logic [11:0] out_saw_tri;
   logic [7:0]  out_noise;

   assign freq = {f[2], f[1], f[0]};
   assign pw   = {p[2], p[1], p[0]};
   assign ctrl = {c[2], c[1], c[0]};

   sid_waveform_bank #(.VOICES(V), .OSC_W(OW), .NOISE_TTL(TTL), .OSC_INIT(1)) dut (
      .clk(clk), .res(res), .tick(tick), .freq(freq), .pw(pw), .ctrl(ctrl),
      .busy(busy), .overrun(overrun), .out_valid(out_valid), .out_voice(out_voice),
      .out_sel(out_sel), .out_saw_tri(out_saw_tri), .out_pulse(out_pulse),
      .out_noise(out_noise)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  voice;
      logic [3:0]  sel;
      logic [11:0] st;
      logic        pulse;
      logic [7:0]  nz;
   } emit_t;

   emit_t exp_q[$];
   emit_t last_e;
   emit_t e_cmp;
   int total = 0;
   int bad   = 0;
   int last_busy;

   logic [23:0] m_osc [3];
   logic [22:0] m_noise [3];
   logic [23:0] m_age [3];
   logic        m_prev [3];

   logic [11:0] cap_st [3];
   logic        cap_pulse [3];
   logic [7:0]  cap_nz [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [7:0] taps(input logic [22:0] n);
      return {n[20], n[18], n[14], n[11], n[9], n[5], n[2], n[0]};
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 3; v++) begin
         m_osc[v]   = 24'h555555;
         m_noise[v] = '1;
         m_age[v]   = '0;
         m_prev[v]  = 1'b0;
      end
      exp_q.delete();
      last_e = '0;
   endtask

   // One whole sweep computed at once from the current inputs
   task automatic model_sweep();
      logic [23:0] nx [3];
      logic [23:0] nw [3];
      logic        r [3];
      logic        rq [3];
      logic        pl [3];
      logic [22:0] nz;
      logic [11:0] t;
      logic        x;
      int          s;
      emit_t       e;
      for (int v = 0; v < 3; v++) begin
         nx[v] = m_osc[v] + {8'h00, f[v]};
         r[v]  = !m_osc[v][23] && nx[v][23];
         pl[v] = (m_osc[v][23:12] >= p[v]) || c[v][3];
      end
      for (int v = 0; v < 3; v++) begin
         s     = (v + 2) % 3;
         rq[v] = c[v][1] && r[s];
      end
      for (int v = 0; v < 3; v++) begin
         s     = (v + 2) % 3;
         nw[v] = (c[v][3] || (rq[v] && !rq[s] && !c[s][3])) ? 24'h0 : nx[v];
         nz    = m_noise[v];
         if (c[v][3]) begin
            if (m_age[v] == TTL) nz = '1;
            if (m_age[v] != 24'hFFFFFF) m_age[v] = m_age[v] + 1;
         end else if (m_age[v] != 0) begin
            nz       = {nz[21:0], 1'b1};
            m_age[v] = 0;
         end else if (!m_prev[v] && nw[v][19]) begin
            nz = {nz[21:0], nz[22] ^ nz[17]};
         end
         if (c[v][7] && c[v][6:4] != 3'b000) nz = nz & ~23'h144A25;
         m_noise[v] = nz;
         m_prev[v]  = nw[v][19];
      end
      for (int v = 0; v < 3; v++) m_osc[v] = nw[v];
      for (int v = 0; v < 3; v++) begin
         s       = (v + 2) % 3;
         t       = m_osc[v][23:12];
         x       = !c[v][5] && (m_osc[v][23] ^ (c[v][2] && !m_osc[s][23]));
         e.voice = 2'(v);
         e.sel   = c[v][7:4];
         e.st    = x ? {t[11], ~t[10:0]} : t;
         e.pulse = pl[v];
         e.nz    = taps(m_noise[v]);
         exp_q.push_back(e);
      end
   endtask

   // Compare every emitted voice against the model; between emits check hold
   always @(negedge clk) begin
      if (!res) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_emit: got voice %0d expected none", out_voice);
            end else begin
               e_cmp = exp_q.pop_front();
               chk("emit_voice", 32'(out_voice), 32'(e_cmp.voice));
               chk("emit_sel", 32'(out_sel), 32'(e_cmp.sel));
               chk("emit_saw_tri", 32'(out_saw_tri), 32'(e_cmp.st));
               chk("emit_pulse", 32'(out_pulse), 32'(e_cmp.pulse));
               chk("emit_noise", 32'(out_noise), 32'(e_cmp.nz));
               last_e = e_cmp;
               cap_st[e_cmp.voice]    = out_saw_tri;
               cap_pulse[e_cmp.voice] = out_pulse;
               cap_nz[e_cmp.voice]    = out_noise;
            end
         end else begin
            chk("hold", 32'({out_voice, out_sel, out_saw_tri, out_pulse, out_noise}), 32'(last_e));
         end
      end
   end

   // Called at posedge+1; issues one tick and waits (bounded) for the sweep
   task automatic sweep(input bit inject);
      int cnt;
      tick = 1'b1;
      model_sweep();
      @(posedge clk); #1;
      tick = 1'b0;
      cnt  = 0;
      while (busy && cnt < 50) begin
         cnt++;
         tick = inject && (cnt == 3);
         @(posedge clk); #1;
      end
      tick = 1'b0;
      last_busy = cnt;
      if (cnt >= 50) begin
         total++;
         bad++;
         $display("FAIL sweep_timeout: got busy after %0d cycles expected idle", cnt);
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic set_all(input logic [7:0] cc, input logic [15:0] ff);
      for (int v = 0; v < 3; v++) begin
         c[v] = cc;
         f[v] = ff;
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int v = 0; v < 3; v++) begin
         p[v] = '0;
         cap_st[v] = '0;
         cap_pulse[v] = 1'b0;
         cap_nz[v] = '0;
      end
      set_all(8'h20, 16'h0000);
      model_reset();
      res = 1'b1;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;
      @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_saw_tri", 32'(out_saw_tri), 32'd0);
      chk("rst_noise", 32'(out_noise), 32'd0);

      // first sweep: reset pattern visible, voice 0 advanced by 0x1000
      f[0] = 16'h1000;
      sweep(1'b0);
      chk("busy_cycles", 32'(last_busy), 32'd9);
      chk("lit_v0_556", 32'(cap_st[0]), 32'h556);
      chk("lit_v1_555", 32'(cap_st[1]), 32'h555);
      chk("lit_v2_noise_ff", 32'(cap_nz[2]), 32'hFF);
      chk("model_osc0", 32'(m_osc[0]), 32'h556555);

      // hard sync: voice 1 follows voice 0's MSB rise on tick 256; voice 2 ring+tri
      set_all(8'h28, 16'h0000);
      sweep(1'b0);
      c[0] = 8'h20; c[1] = 8'h22; c[2] = 8'h14;
      f[0] = 16'h8000; f[1] = 16'h0100; f[2] = 16'h0000;
      for (int k = 1; k <= 256; k++) begin
         sweep(1'b0);
         if (k == 255) chk("lit_v1_tick255", 32'(cap_st[1]), 32'h00F);
      end
      chk("lit_v0_tick256", 32'(cap_st[0]), 32'h800);
      chk("lit_v1_synced", 32'(cap_st[1]), 32'h000);
      chk("lit_v2_ring_tri", 32'(cap_st[2]), 32'h7FF);
      chk("model_osc1_zero", 32'(m_osc[1]), 32'h0);

      // all voices sync-requested in the same sweep: nobody is zeroed
      set_all(8'h28, 16'h0000);
      sweep(1'b0);
      set_all(8'h22, 16'h8000);
      repeat (256) sweep(1'b0);
      for (int v = 0; v < 3; v++) chk("lit_all_sync_kept", 32'(cap_st[v]), 32'h800);
      chk("model_osc2", 32'(m_osc[2]), 32'h800000);

      // pulse at the width boundary; noise mixed with saw clears taps
      set_all(8'h20, 16'h0000);
      p[0] = 12'h800; c[0] = 8'h40; c[1] = 8'hA0;
      sweep(1'b0);
      chk("lit_pulse_800", 32'(cap_pulse[0]), 32'd1);
      chk("lit_noise_mixed", 32'(cap_nz[1]), 32'h00);

      set_all(8'h28, 16'h0000);
      sweep(1'b0);
      c[0] = 8'h40; c[1] = 8'h20; c[2] = 8'h20;
      f[0] = 16'h7FF0; f[1] = 16'h0000; f[2] = 16'h0000;
      repeat (256) sweep(1'b0);
      chk("model_osc0_7ff", 32'(m_osc[0]), 32'h7FF000);
      f[0] = 16'h0000;
      chk("overrun_before", 32'(overrun), 32'd0);
      sweep(1'b1);
      chk("lit_pulse_7ff", 32'(cap_pulse[0]), 32'd0);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      chk("busy_with_extra_tick", 32'(last_busy), 32'd9);
      f[0] = 16'h1000;
      sweep(1'b0);
      f[0] = 16'h0000;
      sweep(1'b0);
      chk("lit_pulse_again", 32'(cap_pulse[0]), 32'd1);

      // test held past the TTL refills the LFSR; release shifts in a one
      c[0] = 8'h08;
      repeat (TTL + 1) sweep(1'b0);
      chk("lit_noise_refill", 32'(cap_nz[0]), 32'hFF);
      c[0] = 8'h00;
      sweep(1'b0);
      chk("lit_noise_release", 32'(cap_nz[0]), 32'hFF);
      chk("model_noise0", 32'(m_noise[0]), 32'h7FFFFF);
      chk("overrun_still", 32'(overrun), 32'd1);

      // reset in the middle of a sweep leaves no trace
      set_all(8'h20, 16'h0000);
      f[0] = 16'h1000;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      res = 1'b1;
      model_reset();
      repeat (2) begin
         @(posedge clk); #1;
      end
      res = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;
      sweep(1'b0);
      chk("lit_after_midrst", 32'(cap_st[0]), 32'h556);
      chk("lit_after_midrst_v2", 32'(cap_st[2]), 32'h555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sid_waveform_bank.md
SID_WAVEFORM_BANK -- requirements
Module: sid_waveform_bank

Interface
REQ-001 SHALL have parameter VOICES, default 3, meaning the number of time-multiplexed voices (2..8).
REQ-002 SHALL have parameter OSC_W, default 24, meaning the oscillator accumulator width (16..32).
REQ-003 SHALL have parameter NOISE_TTL, default 'h8000, meaning the test-held tick count after which the LFSR refills with ones.
REQ-004 SHALL have parameter OSC_INIT, default 1, meaning that 1 gives an alternating-01 reset pattern (e.g. 'h555555) and 0 gives zero.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 res  in  1  reset, asynchronous and active-high.
REQ-007 tick  in  1  one-cycle pulse that starts one SID-cycle update sweep over all voices.
REQ-008 freq  in  VOICES*16  per-voice frequency; voice v is bits [16v+15:16v].
REQ-009 pw  in  VOICES*12  per-voice pulse width.
REQ-010 ctrl  in  VOICES*8  per-voice {noise,pulse,saw,tri,test,ring,sync,gate}, MSB first.
REQ-011 busy  out  1  high while a sweep is in progress.
REQ-012 overrun  out  1  sticky flag: a tick arrived while busy.
REQ-013 out_valid  out  1  high for one cycle per emitted voice.
REQ-014 out_voice  out  $clog2(VOICES)  index of the emitted voice.
REQ-015 out_sel  out  4  {noise,pulse,saw,tri} of the emitted voice.
REQ-016 out_saw_tri  out  12  saw/triangle bits.
REQ-017 out_pulse  out  1  pulse bit.
REQ-018 out_noise  out  8  LFSR taps {20,18,14,11,9,5,2,0}.

Function
REQ-019 SHALL hold per-voice state in arrays: osc[OSC_W], noise[23], pulse, osc19_prev, test_age[24].
REQ-020 SHALL implement FSM IDLE->CALC->COMMIT->EMIT->IDLE, processing one voice per cycle in each non-IDLE state, voice index 0..VOICES-1.
REQ-021 In IDLE, tick SHALL enter CALC at voice 0; busy=1 from the next cycle until EMIT completes (3*VOICES cycles).
REQ-022 A tick while busy SHALL be ignored and SHALL set overrun; only res clears it.
REQ-023 CALC SHALL compute nxt[v]=osc[v]+zero-extended freq[v], modulo 2^OSC_W, and rise[v]=~osc[v][MSB] & nxt[v][MSB].
REQ-024 CALC SHALL latch pulse[v]=(osc[v][MSB:MSB-11] >= pw[v]) | test[v], using pre-update osc.
REQ-025 The sync source of voice v SHALL be s=(v+VOICES-1) mod VOICES; req[v]=sync[v] & rise[s].
REQ-026 COMMIT SHALL set osc[v]=0 if test[v] | (req[v] & ~req[s] & ~test[s]); otherwise osc[v]=nxt[v].
REQ-027 When all voices assert req in the same sweep, no voice SHALL be synced.
REQ-028 COMMIT noise: a rise of osc bit OSC_W-5 versus osc19_prev, with test low, SHALL shift noise={noise[21:0], noise[22]^noise[17]} once.
REQ-029 COMMIT noise: while test[v]=1, test_age SHALL increment per sweep (saturating), and noise SHALL become all ones when test_age==NOISE_TTL.
REQ-030 On test falling, the LFSR SHALL shift once with feedback forced to 1; test_age SHALL clear.
REQ-031 COMMIT noise: with noise selected together with any other waveform, the eight tap bits SHALL be written to 0.
REQ-032 EMIT SHALL output the post-COMMIT state with out_valid=1; out_saw_tri={o[MSB], o[MSB-1:MSB-11] ^ {11{x}}}, where o is the top 12 bits of osc and x=~saw & (osc[v][MSB] ^ (ring & ~osc[s][MSB])).
REQ-033 Outputs other than out_valid SHALL hold their last values between emits.

Reset
REQ-034 On res, asynchronously: FSM=IDLE; busy, overrun, out_valid, out_* =0; osc=OSC_INIT pattern; noise='1; pulse, osc19_prev, test_age=0.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep with no partial commit visible after release.

Verification
REQ-036 Reset, VOICES=3, OSC_W=24 -> every osc='h555555, noise='h7FFFFF, busy=0, no out_valid.
REQ-037 freq0='h1000, saw0=1, tick -> busy for 9 cycles; emits voices 0,1,2 in order; voice 0 out_saw_tri='h556.
REQ-038 Test pulse clears all osc; freq0='h8000, sync1=1, freq1='h0100; 256 ticks -> on tick 256 osc0='h800000 and osc1=0, with no sync on other ticks.
REQ-039 sync=1 on all voices, all rising the same sweep -> no osc zeroed; each osc=nxt.
REQ-040 pw0='h800, osc0 top='h800 -> out_pulse=1 on next sweep; top='h7FF -> 0; tick during busy -> ignored, overrun=1.
REQ-041 test0 held NOISE_TTL+1 sweeps -> noise0='h7FFFFF; release -> one shift, out_noise='hFF.
